// File: rtl/nids_pkg.sv
// Shared widths, default depth and output-framing state encoding for the
// NIDS ingress path (input FIFOs and the downstream arbiter).
package nids_pkg;

    localparam int NIDS_DATA_W = 64;
    localparam int NIDS_CTRL_W = 8;
    localparam int NIDS_DEPTH  = 16;

    typedef enum logic [1:0] {
        WAIT_HDR = 2'd0,
        IN_HDR   = 2'd1,
        IN_PAY   = 2'd2
    } frame_state_e;

    // A nonzero control word marks a header or trailer word.
    function automatic frame_state_e frame_next(input frame_state_e state,
                                                input logic         marker);
        frame_state_e nxt;
        nxt = state;
        case (state)
            WAIT_HDR: if (marker)  nxt = IN_HDR;
            IN_HDR:   if (!marker) nxt = IN_PAY;
            IN_PAY:   if (marker)  nxt = WAIT_HDR;
            default:               nxt = WAIT_HDR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/nids_fifo_mem.sv
// Word storage for the input FIFO: one synchronous write port and one
// asynchronous read port so the head word falls through combinationally.
module nids_fifo_mem
    import nids_pkg::*;
#(
    parameter int DATA_W = NIDS_DATA_W,
    parameter int CTRL_W = NIDS_CTRL_W,
    parameter int DEPTH  = NIDS_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int WORD_W = DATA_W + CTRL_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_word
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Contents are not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    assign rd_word = mem_q[rd_addr];

endmodule

// File: rtl/nids_in_fifo.sv
// First-word-fall-through ingress FIFO with an output framing checker that
// counts forwarded packets and flags payload words seen outside a packet.
//
//   state    | meaning
//   WAIT_HDR | between packets, next popped word should be a header
//   IN_HDR   | inside a (possibly multi-word) header
//   IN_PAY   | inside payload, next marker word is the trailer
module nids_in_fifo
    import nids_pkg::*;
#(
    parameter int DATA_W = NIDS_DATA_W,
    parameter int CTRL_W = NIDS_CTRL_W,
    parameter int DEPTH  = NIDS_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_wr,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_wr,
    input  logic              out_rdy,
    output logic [CW-1:0]     fifo_cnt,
    output logic [15:0]       pkt_cnt,
    output logic              frame_err
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    frame_state_e  state_q, state_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic          frame_err_q, frame_err_d;

    logic                     push;
    logic                     pop;
    logic                     head_marker;
    logic [DATA_W+CTRL_W-1:0] head_word;

    // in_rdy depends only on the registered count, so a pop in the same
    // cycle never frees space for a push until the following cycle.
    assign in_rdy = (cnt_q != CW'(DEPTH));
    assign out_wr = (cnt_q != '0) && out_rdy;
    assign push   = in_wr && in_rdy;
    assign pop    = out_wr;

    nids_fifo_mem #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_word ({in_ctrl, in_data}),
        .rd_addr (rd_ptr_q),
        .rd_word (head_word)
    );

    assign out_data    = head_word[DATA_W-1:0];
    assign out_ctrl    = head_word[DATA_W +: CTRL_W];
    assign head_marker = |out_ctrl;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Framing only observes popped words; data is forwarded regardless.
    always_comb begin
        state_d     = state_q;
        pkt_cnt_d   = pkt_cnt_q;
        frame_err_d = 1'b0;
        if (pop) begin
            state_d = frame_next(state_q, head_marker);
            if (state_q == WAIT_HDR && !head_marker) begin
                frame_err_d = 1'b1;
            end
            if (state_q == IN_PAY && head_marker) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            state_q     <= WAIT_HDR;
            pkt_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            pkt_cnt_q   <= pkt_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign fifo_cnt  = cnt_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_nids_in_fifo.sv
// Scoreboard bench for nids_in_fifo: directed stimulus pushes expected words,
// a negedge monitor pops and compares whenever the FIFO presents out_wr.
module tb_nids_in_fifo;
    import nids_pkg::*;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [63:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [4:0]  fifo_cnt;
    logic [15:0] pkt_cnt;
    logic        frame_err;

    always #5 clk = ~clk;

    nids_in_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_wr     (in_wr),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy),
        .fifo_cnt  (fifo_cnt),
        .pkt_cnt   (pkt_cnt),
        .frame_err (frame_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    word_t        sb_q[$];
    int           m_cnt = 0;
    logic [15:0]  m_pkt = '0;
    logic         m_ferr = 1'b0;
    frame_state_e m_state = WAIT_HDR;
    bit           m_live = 1'b0;
    bit           popped = 1'b0;
    logic [7:0]   popped_ctrl = '0;
    int           n_pops = 0;

    always @(posedge clk) begin : model
        bit do_pop;
        bit do_push;
        if (reset) begin
            sb_q.delete();
            m_cnt   = 0;
            m_pkt   = '0;
            m_ferr  = 1'b0;
            m_state = WAIT_HDR;
            popped  = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            do_pop  = (m_cnt != 0) && out_rdy;
            do_push = in_wr && (m_cnt != DEPTH);
            m_ferr  = 1'b0;
            if (do_pop && popped) begin
                if (m_state == WAIT_HDR) begin
                    if (popped_ctrl != 8'h00) m_state = IN_HDR;
                    else                      m_ferr = 1'b1;
                end else if (m_state == IN_HDR) begin
                    if (popped_ctrl == 8'h00) m_state = IN_PAY;
                end else begin
                    if (popped_ctrl != 8'h00) begin
                        m_state = WAIT_HDR;
                        m_pkt   = m_pkt + 16'd1;
                    end
                end
            end
            popped = 1'b0;
            if (do_push) sb_q.push_back({in_ctrl, in_data});
            if (do_push && !do_pop) m_cnt++;
            if (do_pop && !do_push) m_cnt--;
        end
    end

    always @(negedge clk) begin : monitor
        word_t e;
        if (m_live) begin
            check("out_wr", 64'(out_wr), 64'((m_cnt != 0) && out_rdy));
            check("fifo_cnt", 64'(fifo_cnt), 64'(m_cnt));
            check("in_rdy", 64'(in_rdy), 64'(m_cnt != DEPTH));
            check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
            check("frame_err", 64'(frame_err), 64'(m_ferr));
            if (out_wr) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: out_wr=1 with no expected word at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                    check("out_data", out_data, e.data);
                    popped      = 1'b1;
                    popped_ctrl = e.ctrl;
                    n_pops++;
                end
            end
        end
    end

    // Apply inputs for one rising edge; returns 1 time unit after that edge.
    task automatic step(input logic wr, input logic [7:0] c, input logic [63:0] d, input logic rdy);
        in_wr   = wr;
        in_ctrl = c;
        in_data = d;
        out_rdy = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 64'h0, rdy);
    endtask

    initial begin : stim
        int p0;
        reset   = 1'b1;
        in_wr   = 1'b0;
        in_ctrl = '0;
        in_data = '0;
        out_rdy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);

        // Basic three-word packet
        p0 = n_pops;
        step(1'b1, 8'hFF, 64'h1111_0000_0000_0001, 1'b1);
        step(1'b1, 8'h00, 64'h2222_0000_0000_0002, 1'b1);
        step(1'b1, 8'h01, 64'h3333_0000_0000_0003, 1'b1);
        idle(1, 1'b1);
        check("basic_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("basic_pops", 64'(n_pops - p0), 64'd3);

        // Fill to full with downstream stalled; 17th word is dropped
        p0 = n_pops;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, (i == 0) ? 8'h01 : ((i == 16) ? 8'h02 : 8'h00),
                 64'hA000 + 64'(i), 1'b0);
            if (i == 15) begin
                check("full_cnt16", 64'(fifo_cnt), 64'd16);
                check("full_in_rdy", 64'(in_rdy), 64'd0);
            end
        end
        check("full_after17", 64'(fifo_cnt), 64'd16);

        // Push while full with pop: only the pop happens
        step(1'b1, 8'h00, 64'hBAD0, 1'b1);
        check("simul_full_cnt", 64'(fifo_cnt), 64'd15);
        check("simul_full_rdy", 64'(in_rdy), 64'd1);
        idle(10, 1'b1);
        check("drain_to5", 64'(fifo_cnt), 64'd5);
        step(1'b1, 8'h03, 64'hC003, 1'b1);
        check("pushpop_5", 64'(fifo_cnt), 64'd5);
        idle(6, 1'b1);
        check("drain_empty", 64'(fifo_cnt), 64'd0);
        check("full_pops", 64'(n_pops - p0), 64'd17);
        check("full_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // Payload word with no header: flagged, still forwarded
        p0 = n_pops;
        step(1'b1, 8'h00, 64'hE0E0, 1'b1);
        idle(1, 1'b1);
        check("ferr_pulse", 64'(frame_err), 64'd1);
        check("ferr_pkt", 64'(pkt_cnt), 64'd2);
        check("ferr_fwd", 64'(n_pops - p0), 64'd1);
        idle(1, 1'b1);
        check("ferr_clear", 64'(frame_err), 64'd0);
        step(1'b1, 8'h10, 64'hD001, 1'b1);
        step(1'b1, 8'h00, 64'hD002, 1'b1);
        step(1'b1, 8'h20, 64'hD003, 1'b1);
        idle(1, 1'b1);
        check("recover_pkt", 64'(pkt_cnt), 64'd3);

        // Packet counter wraps
        force dut.pkt_cnt_q = 16'hFFFF;
        m_pkt = 16'hFFFF;
        #2;
        release dut.pkt_cnt_q;
        step(1'b1, 8'hFF, 64'hF001, 1'b1);
        step(1'b1, 8'h00, 64'hF002, 1'b1);
        step(1'b1, 8'h01, 64'hF003, 1'b1);
        idle(1, 1'b1);
        check("wrap_pkt", 64'(pkt_cnt), 64'd0);

        // Reset mid-packet with 7 words queued in IN_PAY
        step(1'b1, 8'h01, 64'h7001, 1'b1);
        step(1'b1, 8'h00, 64'h7002, 1'b1);
        step(1'b1, 8'h02, 64'h7003, 1'b1);
        step(1'b1, 8'h01, 64'h7004, 1'b1);
        step(1'b1, 8'h00, 64'h7005, 1'b1);
        idle(1, 1'b1);
        check("mid_pkt_cnt", 64'(pkt_cnt), 64'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'h00, 64'h7100 + 64'(i), 1'b0);
        check("mid_cnt7", 64'(fifo_cnt), 64'd7);
        reset = 1'b1;
        step(1'b1, 8'h00, 64'h7BAD, 1'b1);
        reset = 1'b0;
        check("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
        check("mid_rst_out_wr", 64'(out_wr), 64'd0);
        check("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
        step(1'b1, 8'h00, 64'hF00D, 1'b1);
        idle(1, 1'b1);
        check("mid_rst_wait_hdr", 64'(frame_err), 64'd1);
        idle(3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
